// File: rtl/e_mdu_pkg.sv
// e_mdu shared definitions: MDUOp encodings, latency defaults
// and a small two's-complement helper used by the divider.
package e_mdu_pkg;

   typedef enum logic [3:0] {
      MDU_NONE  = 4'd0,
      MDU_MULT  = 4'd1,
      MDU_MULTU = 4'd2,
      MDU_DIV   = 4'd3,
      MDU_DIVU  = 4'd4,
      MDU_MFHI  = 4'd5,
      MDU_MFLO  = 4'd6,
      MDU_MTHI  = 4'd7,
      MDU_MTLO  = 4'd8,
      MDU_MADD  = 4'd9,
      MDU_MADDU = 4'd10
   } mdu_op_e;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   function automatic logic [31:0] neg_if(
      input logic        n,
      input logic [31:0] v
   );
      return n ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/e_mdu.sv
// e_mdu: E-stage multiply/divide unit owning HI/LO.
// Ports: clk, rst_n (async low), srcA/srcB operands,
// MDUOp op code; start/busy to hazard unit; hi, lo,
// mdu_out (MFHI/MFLO read, else 0).
// Option: define MDU_MADD_EN to add MADD/MADDU.
module e_mdu
   import e_mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] srcA,
   input  logic [31:0] srcB,
   input  logic [3:0]  MDUOp,
   output logic        start,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] mdu_out
);

   localparam int MAXC =
      (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAXC + 1);

   logic          is_mul;
   logic          is_mulu;
   logic          is_div;
   logic          is_divu;
   logic          is_madd;
   logic          is_maddu;
   logic          is_mthi;
   logic          is_mtlo;
   logic          op_go;
   logic          op_dv;

   logic [63:0]   sprod;
   logic [63:0]   uprod;
   logic [31:0]   ua;
   logic [31:0]   ub;
   logic [31:0]   uq;
   logic [31:0]   ur;
   logic [31:0]   q;
   logic [31:0]   r;
   logic [63:0]   res;
   logic [CW-1:0] lat;

   logic [CW-1:0] cnt;
   logic [63:0]   pend;

   always_comb begin
      is_mul  = (MDUOp == MDU_MULT);
      is_mulu = (MDUOp == MDU_MULTU);
      is_div  = (MDUOp == MDU_DIV);
      is_divu = (MDUOp == MDU_DIVU);
      is_mthi = (MDUOp == MDU_MTHI);
      is_mtlo = (MDUOp == MDU_MTLO);
`ifdef MDU_MADD_EN
      is_madd  = (MDUOp == MDU_MADD);
      is_maddu = (MDUOp == MDU_MADDU);
`else
      is_madd  = 1'b0;
      is_maddu = 1'b0;
`endif
      op_dv = is_div | is_divu;
      op_go = is_mul | is_mulu | op_dv
            | is_madd | is_maddu;
   end

   assign start = op_go & ~busy;

   // Low 64 bits of the sign-extended product are the
   // signed product.
   assign sprod = {{32{srcA[31]}}, srcA}
                * {{32{srcB[31]}}, srcB};
   assign uprod = {32'd0, srcA} * {32'd0, srcB};

   // Signed divide via magnitudes: quotient truncates
   // toward zero, remainder follows the dividend sign.
   // 0x80000000 / -1 falls out as LO=0x80000000, HI=0.
   always_comb begin
      ua = neg_if(is_div & srcA[31], srcA);
      ub = neg_if(is_div & srcB[31], srcB);
      if (ub == 32'd0) begin
         uq = 32'd0;
         ur = 32'd0;
      end else begin
         uq = ua / ub;
         ur = ua % ub;
      end
      q = neg_if(is_div & (srcA[31] ^ srcB[31]), uq);
      r = neg_if(is_div & srcA[31], ur);
   end

   // Divide by zero latches the current HI/LO, so the
   // completion write leaves them as they were. HI/LO
   // cannot change while busy, so this is exact.
   always_comb begin
      res = {hi, lo};
      unique case (1'b1)
         is_mul:          res = sprod;
         is_mulu:         res = uprod;
         is_div, is_divu: begin
            if (srcB == 32'd0)
               res = {hi, lo};
            else
               res = {r, q};
         end
`ifdef MDU_MADD_EN
         is_madd:         res = {hi, lo} + sprod;
         is_maddu:        res = {hi, lo} + uprod;
`endif
         default:         res = {hi, lo};
      endcase
   end

   assign lat = op_dv ? CW'(DIV_CYCLES)
                      : CW'(MULT_CYCLES);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi   <= 32'd0;
         lo   <= 32'd0;
         busy <= 1'b0;
         cnt  <= '0;
         pend <= 64'd0;
      end else if (busy) begin
         if (cnt == CW'(1)) begin
            hi   <= pend[63:32];
            lo   <= pend[31:0];
            busy <= 1'b0;
            cnt  <= '0;
         end else begin
            cnt <= cnt - CW'(1);
         end
      end else if (start) begin
         pend <= res;
         cnt  <= lat;
         busy <= 1'b1;
      end else if (is_mthi) begin
         hi <= srcA;
      end else if (is_mtlo) begin
         lo <= srcA;
      end
   end

   always_comb begin
      mdu_out = 32'd0;
      unique case (1'b1)
         (MDUOp == MDU_MFHI): mdu_out = hi;
         (MDUOp == MDU_MFLO): mdu_out = lo;
         default:             mdu_out = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed self-checking bench for e_mdu.
// Covers MULT/DIV variants, MT/MF, div-by-zero, busy rules, reset abort.
module tb_e_mdu;
   import e_mdu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [31:0] srcA;
   logic [31:0] srcB;
   logic [3:0]  MDUOp;
   logic        start;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] mdu_out;

   int checks;
   int failures;

   e_mdu dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .srcA    (srcA),
      .srcB    (srcB),
      .MDUOp   (MDUOp),
      .start   (start),
      .busy    (busy),
      .hi      (hi),
      .lo      (lo),
      .mdu_out (mdu_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input  logic [31:0] oh,
                            input  logic [31:0] ol,
                            output int n,
                            output logic stable);
      n = 0;
      stable = 1'b1;
      while (busy && n < 40) begin
         if (hi !== oh || lo !== ol) stable = 1'b0;
         step();
         n++;
      end
   endtask

   task automatic do_op(input string tag,
                        input logic [3:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int ncyc,
                        input logic [31:0] eh,
                        input logic [31:0] el);
      logic [31:0] oh;
      logic [31:0] ol;
      int n;
      logic st;
      oh = hi;
      ol = lo;
      MDUOp = op;
      srcA = a;
      srcB = b;
      #1;
      chk({tag, "_start"}, {31'd0, start}, 32'd1);
      step();
      MDUOp = MDU_NONE;
      wait_done(oh, ol, n, st);
      chk({tag, "_cycles"}, n, ncyc);
      chk({tag, "_stable"}, {31'd0, st}, 32'd1);
      chk({tag, "_hi"}, hi, eh);
      chk({tag, "_lo"}, lo, el);
   endtask

   initial begin
      int n;
      logic st;
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      srcA = 32'd0;
      srcB = 32'd0;
      MDUOp = MDU_NONE;
      #22;
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_out", mdu_out, 32'd0);
      rst_n = 1'b1;
      step();

      do_op("mult", MDU_MULT, 32'hFFFFFFFE, 32'd3,
            5, 32'hFFFFFFFF, 32'hFFFFFFFA);
      do_op("multu", MDU_MULTU, 32'hFFFFFFFE, 32'd3,
            5, 32'h00000002, 32'hFFFFFFFA);
      do_op("div", MDU_DIV, 32'hFFFFFFF9, 32'd2,
            10, 32'hFFFFFFFF, 32'hFFFFFFFD);
      do_op("divu", MDU_DIVU, 32'd7, 32'd2,
            10, 32'd1, 32'd3);
      do_op("divovf", MDU_DIV, 32'h80000000,
            32'hFFFFFFFF, 10, 32'd0, 32'h80000000);
      do_op("divneg", MDU_DIV, 32'd7, 32'hFFFFFFFE,
            10, 32'd1, 32'hFFFFFFFD);

      MDUOp = MDU_MTHI;
      srcA = 32'h12345678;
      #1;
      chk("mthi_start", {31'd0, start}, 32'd0);
      step();
      chk("mthi_hi", hi, 32'h12345678);
      chk("mthi_lo", lo, 32'hFFFFFFFD);
      MDUOp = MDU_MFHI;
      #1;
      chk("mfhi", mdu_out, 32'h12345678);
      MDUOp = MDU_MFLO;
      #1;
      chk("mflo", mdu_out, 32'hFFFFFFFD);
      MDUOp = MDU_NONE;
      #1;
      chk("mfnone", mdu_out, 32'd0);
      MDUOp = MDU_MTLO;
      srcA = 32'hCAFEBABE;
      step();
      MDUOp = MDU_NONE;
      chk("mtlo_lo", lo, 32'hCAFEBABE);
      chk("mtlo_hi", hi, 32'h12345678);

      do_op("div0", MDU_DIV, 32'd5, 32'd0,
            10, 32'h12345678, 32'hCAFEBABE);
      do_op("divu0", MDU_DIVU, 32'hFFFFFFFF, 32'd0,
            10, 32'h12345678, 32'hCAFEBABE);

      MDUOp = MDU_MULT;
      srcA = 32'd3;
      srcB = 32'd4;
      #1;
      chk("ovl_start", {31'd0, start}, 32'd1);
      step();
      MDUOp = MDU_MTLO;
      srcA = 32'hDEADBEEF;
      #1;
      chk("ovl_mtlo_st", {31'd0, start}, 32'd0);
      step();
      chk("ovl_mtlo_lo", lo, 32'hCAFEBABE);
      MDUOp = MDU_MULT;
      srcA = 32'd100;
      srcB = 32'd100;
      #1;
      chk("ovl_mult_st", {31'd0, start}, 32'd0);
      step();
      MDUOp = MDU_NONE;
      wait_done(32'h12345678, 32'hCAFEBABE, n, st);
      chk("ovl_cycles", n, 3);
      chk("ovl_stable", {31'd0, st}, 32'd1);
      chk("ovl_hi", hi, 32'd0);
      chk("ovl_lo", lo, 32'd12);
      step();
      chk("ovl_idle", {31'd0, busy}, 32'd0);

      MDUOp = MDU_DIV;
      srcA = 32'd100;
      srcB = 32'd7;
      step();
      MDUOp = MDU_NONE;
      step();
      step();
      step();
      chk("abort_busy0", {31'd0, busy}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_hi", hi, 32'd0);
      chk("abort_lo", lo, 32'd0);
      #3;
      rst_n = 1'b1;
      st = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0)
            st = 1'b0;
      end
      chk("abort_quiet", {31'd0, st}, 32'd1);

      MDUOp = MDU_MTLO;
      srcA = 32'hFFFFFFFF;
      step();
      MDUOp = MDU_NONE;
      chk("madd_pre_lo", lo, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
      do_op("maddu", MDU_MADDU, 32'd1, 32'd1,
            5, 32'd1, 32'd0);
`else
      MDUOp = MDU_MADDU;
      srcA = 32'd1;
      srcB = 32'd1;
      #1;
      chk("maddu_off_st", {31'd0, start}, 32'd0);
      step();
      MDUOp = MDU_NONE;
      chk("maddu_off_busy", {31'd0, busy}, 32'd0);
      chk("maddu_off_lo", lo, 32'hFFFFFFFF);
`endif

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
